// File: rtl/dlatch_bank_write_arbiter_if.sv
// Bus between the requesting blocks, the write arbiter and the latch bank.
//   Req     requester -> arbiter   per-requester write request (level, held until Ack)
//   AddrIn  requester -> arbiter   packed word addresses, requester i at [i*AW +: AW]
//   DataIn  requester -> arbiter   packed write data, requester i at [i*DWIDTH +: DWIDTH]
//   Grant   arbiter -> requester   one-hot owner of the current write
//   Ack     arbiter -> requester   one-hot, one-cycle pulse when the write is done
//   Err     arbiter -> requester   pulses with Ack when the address was out of range
//   D       arbiter -> latch bank  shared data bus
//   En      arbiter -> latch bank  one-hot word enables, at most one bit high
//   Busy    arbiter -> requester   high whenever a write is in progress
// Handshake: a requester raises Req[i] with stable AddrIn/DataIn and keeps Req[i]
// high until it sees Ack[i]; address and data are captured at the grant, so later
// changes (including dropping Req) do not affect the write already in flight.
interface dlatch_bank_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 8,
  parameter int DEPTH   = 4,
  parameter int AW      = 2
);
  logic [NUM_REQ-1:0]        Req;
  logic [NUM_REQ*AW-1:0]     AddrIn;
  logic [NUM_REQ*DWIDTH-1:0] DataIn;
  logic [NUM_REQ-1:0]        Grant;
  logic [NUM_REQ-1:0]        Ack;
  logic                      Err;
  logic [DWIDTH-1:0]         D;
  logic [DEPTH-1:0]          En;
  logic                      Busy;

  modport master (
    output Req, AddrIn, DataIn,
    input  Grant, Ack, Err, D, En, Busy
  );

  modport slave (
    input  Req, AddrIn, DataIn,
    output Grant, Ack, Err, D, En, Busy
  );
endinterface

// File: rtl/dlatch_bank_write_arbiter.sv
// Round-robin arbiter and write sequencer for a bank of DEPTH D-latch words.
// A granted write runs SETUP (D valid, En low) -> PULSE (En[addr] high for
// EN_CYCLES cycles) -> HOLD (En low, D held, Ack/Err pulse) so D is stable
// around every enable pulse.
// Ports:
//   Clk        rising-edge clock
//   Rst        synchronous active-high reset
//   bus        slave side of dlatch_bank_write_arbiter_if (requests in, grant/ack/latch drive out)
//   dbg_state  current sequencer state (0 IDLE, 1 SETUP, 2 PULSE, 3 HOLD)
module dlatch_bank_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DWIDTH    = 8,
  parameter int DEPTH     = 4,
  parameter int AW        = 2,
  parameter int EN_CYCLES = 1
) (
  input  logic                        Clk,
  input  logic                        Rst,
  dlatch_bank_write_arbiter_if.slave  bus,
  output logic [1:0]                  dbg_state
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(EN_CYCLES - 1);
  localparam logic [AW:0]        DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [PW-1:0]      PTR_LAST = PW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_REQ  = NUM_REQ'(1);
  localparam logic [DEPTH-1:0]   ONE_EN   = DEPTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] cnt;

  logic          found;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          addr_bad;

  assign dbg_state = state;
  assign addr_bad  = ({1'b0, addr_q} >= DEPTH_W);

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && bus.Req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      ptr       <= '0;
      addr_q    <= '0;
      cnt       <= '0;
      bus.Grant <= '0;
      bus.Ack   <= '0;
      bus.Err   <= 1'b0;
      bus.D     <= '0;
      bus.En    <= '0;
      bus.Busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.Ack <= '0;
          bus.Err <= 1'b0;
          bus.En  <= '0;
          // D is only reloaded on a grant; it keeps the last written word otherwise.
          if (found) begin
            state     <= SETUP;
            addr_q    <= bus.AddrIn[int'(win)*AW +: AW];
            bus.D     <= bus.DataIn[int'(win)*DWIDTH +: DWIDTH];
            bus.Grant <= ONE_REQ << win;
            bus.Busy  <= 1'b1;
            ptr       <= (win == PTR_LAST) ? '0 : win + PW'(1);
          end
        end
        SETUP: begin
          state  <= PULSE;
          cnt    <= '0;
          // Out-of-range writes still run the full timing but never raise an enable.
          bus.En <= addr_bad ? '0 : (ONE_EN << addr_q);
        end
        PULSE: begin
          if (cnt == CNT_LAST) begin
            state   <= HOLD;
            bus.En  <= '0;
            bus.Ack <= bus.Grant;
            bus.Err <= addr_bad;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          state     <= IDLE;
          bus.Ack   <= '0;
          bus.Err   <= 1'b0;
          bus.Grant <= '0;
          bus.Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlatch_bank_write_arbiter.sv
module tb_dlatch_bank_write_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int DEP = 3;
  localparam int AW  = 2;
  localparam int EN  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  dlatch_bank_write_arbiter_if #(.NUM_REQ(NR), .DWIDTH(DW), .DEPTH(DEP), .AW(AW)) bus();

  dlatch_bank_write_arbiter #(
    .NUM_REQ(NR), .DWIDTH(DW), .DEPTH(DEP), .AW(AW), .EN_CYCLES(EN)
  ) dut (
    .Clk       (clk),
    .Rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [NR-1:0] grant;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   start;
  } txn_t;

  txn_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A write starts at the edge where the arbiter is free and someone requests;
  // it then occupies EN+3 edges before the next request can be sampled.
  int m_ptr = 0;
  int free_at = 0;
  logic [DW-1:0] last_d = '0;

  always @(posedge clk) begin
    txn_t t;
    int w;
    cyc = cyc + 1;
    if (rst) begin
      exp_q.delete();
      m_ptr   = 0;
      free_at = cyc + 1;
      last_d  = '0;
    end else if (cyc >= free_at && bus.Req != '0) begin
      w = -1;
      for (int off = 0; off < NR; off++)
        if (w < 0 && bus.Req[(m_ptr + off) % NR]) w = (m_ptr + off) % NR;
      t.grant = '0;
      t.grant[w] = 1'b1;
      t.addr  = bus.AddrIn[w*AW +: AW];
      t.data  = bus.DataIn[w*DW +: DW];
      t.start = cyc;
      exp_q.push_back(t);
      last_d  = t.data;
      m_ptr   = (w + 1) % NR;
      free_at = cyc + EN + 3;
    end
  end

  // ---------------- monitor ----------------
  logic [NR-1:0]  e_grant, e_ack;
  logic           e_err, e_busy;
  logic [DEP-1:0] e_en;
  logic [DW-1:0]  e_d;
  int             mk;

  always @(negedge clk) begin
    if (cyc > 0) begin
      txn_t t;
      e_grant = '0; e_ack = '0; e_err = 1'b0; e_en = '0; e_busy = 1'b0;
      e_d = last_d; mk = -1;
      if (exp_q.size() > 0) begin
        t = exp_q[0];
        mk = cyc - int'(t.start);
        e_grant = t.grant;
        e_busy  = 1'b1;
        e_d     = t.data;
        if (mk >= 1 && mk <= EN && int'(t.addr) < DEP) begin
          e_en = '0;
          e_en[t.addr] = 1'b1;
        end
        if (mk == EN + 1) begin
          e_ack = t.grant;
          e_err = (int'(t.addr) >= DEP);
        end
      end
      chk("grant", 32'(bus.Grant), 32'(e_grant));
      chk("ack",   32'(bus.Ack),   32'(e_ack));
      chk("err",   32'(bus.Err),   32'(e_err));
      chk("d",     32'(bus.D),     32'(e_d));
      chk("en",    32'(bus.En),    32'(e_en));
      chk("busy",  32'(bus.Busy),  32'(e_busy));
      chk("en_onehot", 32'($countones(bus.En) <= 1), 32'd1);
      if (mk == EN + 1) void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.Req[i] = 1'b1;
    bus.AddrIn[i*AW +: AW] = a;
    bus.DataIn[i*DW +: DW] = d;
  endtask

  task automatic wait_for(input bit is_ack, input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_ack ? bus.Ack[i] : bus.Grant[i]) && n < 60);
    chk(is_ack ? "wait_ack" : "wait_grant",
        32'(is_ack ? bus.Ack[i] : bus.Grant[i]), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.Req = '0;
    bus.AddrIn = '0;
    bus.DataIn = '0;

    // Reset held with every requester asserted.
    bus.Req = '1;
    idle_cycles(5);
    rst = 1'b0;
    bus.Req = '0;
    idle_cycles(2);

    // Single write from requester 1 to word 2.
    set_req(1, 2'd2, 8'hA5);
    wait_for(1'b1, 1);
    bus.Req[1] = 1'b0;
    idle_cycles(3);

    // All requesters held: rotation 0,1,2,3,0.
    for (int i = 0; i < NR; i++) set_req(i, AW'(i % DEP), DW'($urandom));
    idle_cycles(5 * (EN + 3) - 2);
    bus.Req = '0;
    idle_cycles(EN + 5);

    // Out-of-range address.
    set_req(0, 2'd3, 8'h3C);
    wait_for(1'b1, 0);
    bus.Req[0] = 1'b0;
    idle_cycles(2);

    // Reset in the middle of the enable pulse.
    set_req(1, 2'd1, 8'h5A);
    wait_for(1'b0, 1);
    idle_cycles(2);
    rst = 1'b1;
    bus.Req = '0;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 2'd0, 8'h11);
    set_req(2, 2'd2, 8'h22);
    wait_for(1'b1, 0);
    bus.Req[0] = 1'b0;
    wait_for(1'b1, 2);
    bus.Req[2] = 1'b0;
    idle_cycles(2);

    // Request dropped right after grant; write still completes.
    set_req(2, 2'd1, 8'hC3);
    wait_for(1'b0, 2);
    bus.Req[2] = 1'b0;
    bus.DataIn[2*DW +: DW] = 8'h00;
    wait_for(1'b1, 2);
    idle_cycles(2);

    // Random traffic with occasional resets and input churn.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NR; i++) begin
        if (bus.Ack[i]) bus.Req[i] = 1'b0;
        else if (!bus.Req[i] && $urandom_range(0, 3) == 0) bus.Req[i] = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          bus.AddrIn[i*AW +: AW] = AW'($urandom_range(0, 3));
          bus.DataIn[i*DW +: DW] = DW'($urandom);
        end
      end
    end
    rst = 1'b0;
    bus.Req = '0;
    idle_cycles(EN + 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
